nf10_tx_port_demux: RTL
=======================

Name: nf10_tx_port_demux

Overview:
- Sits on the TX path directly downstream of the rldram_stream output and directly upstream of the four 10G MAC ports checked by the TX port checker.
- Consumes one AXI4-Stream of DMA-originated packets.
- Steers each packet to one or more MAC ports according to the NetFPGA one-hot dst_port field in TUSER of the first beat.
- Drops packets that have no MAC destination.

Parameters:
- C_AXIS_DATA_WIDTH, 256: TDATA width for the slave and all masters; TKEEP is C_AXIS_DATA_WIDTH/8.
- C_AXIS_TUSER_WIDTH, 128: TUSER width. Bits [15:0] are len, [23:16] are src_port, [31:24] are dst_port.
- C_NUM_PORTS, 4: number of MAC master ports. Fixed at 4; port n is selected by dst_port bit 2n, i.e. TUSER bits 24, 26, 28, 30.

Ports:
- axi_aclk, in, 1: single clock.
- axi_resetn, in, 1: asynchronous, active-low reset.
- s_axis_tdata / tkeep / tuser / tvalid / tready / tlast: in/in/in/in/out/in, widths C_AXIS_DATA_WIDTH / C_AXIS_DATA_WIDTH/8 / C_AXIS_TUSER_WIDTH / 1 / 1 / 1. Input packet stream.
- m_axis_N_tdata / tkeep / tuser / tvalid / tready / tlast, N = 0..3: out/out/out/out/in/out, same widths. Per-port output streams.
- pkt_cnt_N, out, 32, N = 0..3: packets delivered to port N (feature only).
- drop_cnt, out, 32: packets dropped (feature only).

Behaviour:
- Reset values: all m_axis_N_tvalid = 0, s_axis_tready = 0, FSM = IDLE, done[3:0] = 0, route mask = 0, all counters = 0.
- Asynchronous assertion clears everything immediately, including mid-packet. The interrupted packet is not resumed; the next beat seen after deassertion is treated as a first beat.
- FSM has three states:
  - IDLE: waiting for a first beat. The mask is computed combinationally as sel = {tuser[30], tuser[28], tuser[26], tuser[24]}.
    - If sel == 0, the beat is consumed with s_axis_tready = 1. If the beat is not tlast, go to DROP; increment drop_cnt on the first beat.
    - If sel != 0, forward the beat using sel. When the beat completes and it is not tlast, latch sel into the route mask and go to SEND.
  - SEND: forward beats using the latched route mask. Return to IDLE when the tlast beat completes.
  - DROP: s_axis_tready = 1. Discard beats; return to IDLE on the tlast handshake.
- Beat forwarding uses per-beat done bits so the stream stays AXI-compliant for multicast:
  - m_axis_N_tvalid = s_axis_tvalid & mask[N] & ~done[N].
  - done[N] sets on a port-N handshake while the beat is still incomplete.
  - The beat is complete when every masked port has either done[N] = 1 or is handshaking this cycle. At that point s_axis_tready = 1 for exactly that cycle and all done bits clear.
  - A port, once valid, is never deasserted before its handshake.
- Data, tkeep, tuser and tlast are passed combinationally to every master. Latency is 0 cycles; throughput is 1 beat/cycle when all selected ports are ready.
- Unselected ports see tvalid = 0.
- A single-beat packet (tlast on the first beat) completes in IDLE with no state change.
- Back-to-back packets are supported: the IDLE decision uses the current beat immediately after a tlast completion.
- pkt_cnt_N increments once per packet, on the tlast handshake of port N. drop_cnt increments on the first beat of a dropped packet. All counters wrap at 2^32.
- DMA destination bits (odd dst_port bits) are ignored.

Optional Feature:
- Macro: NF10_TX_DEMUX_STATS_EN.
- Defined: pkt_cnt_N and drop_cnt are implemented as described above.
- Undefined: the counter registers are not built, and pkt_cnt_N / drop_cnt are tied to 0. Routing behaviour is identical in both cases.

Decomposition:
- Shared package holds:
  - TUSER field offsets: LEN_LSB = 0, SRC_LSB = 16, DST_LSB = 24.
  - MAC_PORT_BIT(n) = 2n.
  - FSM state encodings: IDLE, SEND, DROP.
- One sub-module, nf10_tx_demux_beat_ctrl, holds the done-bit and beat-complete logic for the mask and is instantiated once. The FSM and counters stay in the top module.

Test Plan:
- Unicast: 3-beat packet with dst_port = 0x04, all tready = 1 → 3 beats appear on m_axis_1 only, on the same cycles as input; pkt_cnt_1 = 1.
- Multicast skew: 2-beat packet with dst_port = 0x55; m_axis_2_tready is held low for 4 cycles on beat 0 → ports 0, 1, 3 accept beat 0 once each and are not re-presented with it. s_axis_tready pulses only when port 2 accepts. All four ports receive identical beats; each pkt_cnt increments by 1.
- Drop: 4-beat packet with dst_port = 0x02 → s_axis_tready = 1 for all 4 beats, all m tvalid = 0, drop_cnt = 1. The next packet, dst_port = 0x01, routes to port 0.
- Back-to-back single-beat packets: dst_port 0x01 then 0x40 on consecutive cycles → port 0 gets beat 1 and port 3 gets beat 2, with no bubble.
- Reset mid-packet: axi_resetn is asserted on beat 2 of a 5-beat packet to port 0 → all tvalid go to 0 immediately and counters go to 0. After release, a new packet with dst_port = 0x10 routes to port 2.
- Feature off: the same traffic with NF10_TX_DEMUX_STATS_EN undefined → routing is identical, and all counters read 0.

Source files
------------

// File: rtl/nf10_tx_port_demux_pkg.sv
// Shared definitions for the TX port demux: TUSER field offsets, the mapping
// from MAC port number to dst_port bit, and the steering FSM states.
package nf10_tx_port_demux_pkg;

  localparam int NUM_PORTS = 4;

  // TUSER layout: len [15:0], src_port [23:16], dst_port [31:24]
  localparam int LEN_LSB = 0;
  localparam int SRC_LSB = 16;
  localparam int DST_LSB = 24;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  // MAC port n lives on the even dst_port bits; odd bits are DMA queues.
  function automatic int mac_port_bit(input int n);
    return 2 * n;
  endfunction

  // Extract the MAC-port one-hot mask from a dst_port byte.
  function automatic logic [NUM_PORTS-1:0] mac_sel(input logic [7:0] dst);
    logic [NUM_PORTS-1:0] sel;
    sel = '0;
    for (int n = 0; n < NUM_PORTS; n++) begin
      sel[n] = dst[mac_port_bit(n)];
    end
    return sel;
  endfunction

endpackage

// File: rtl/nf10_tx_demux_beat_ctrl.sv
// Per-beat multicast bookkeeping. Each masked port gets the current beat
// exactly once: a port that has accepted is marked done and stops seeing
// tvalid until every masked port has taken the beat, at which point the beat
// is complete, the upstream is released and the done bits clear.
module nf10_tx_demux_beat_ctrl
  import nf10_tx_port_demux_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid,
  input  logic [NUM_PORTS-1:0] mask,
  input  logic [NUM_PORTS-1:0] m_ready,
  output logic [NUM_PORTS-1:0] m_valid,
  output logic                 beat_done
);

  logic [NUM_PORTS-1:0] done_q;
  logic [NUM_PORTS-1:0] done_d;
  logic [NUM_PORTS-1:0] port_hs;

  // Present the beat to masked ports not yet served; detect completion.
  always_comb begin
    m_valid   = {NUM_PORTS{s_valid}} & mask & ~done_q;
    port_hs   = m_valid & m_ready;
    beat_done = s_valid && (mask != '0) &&
                ((mask & ~(done_q | port_hs)) == '0);
    done_d    = beat_done ? '0 : (done_q | port_hs);
  end

  // Done-bit register; cleared asynchronously so a reset abandons the beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= '0;
    end else begin
      done_q <= done_d;
    end
  end

endmodule

// File: rtl/nf10_tx_port_demux.sv
// TX port demux: steers DMA packets from one AXI4-Stream to the four 10G MAC
// ports using the even dst_port bits of the first beat's TUSER, multicasting
// where several bits are set and discarding packets with no MAC destination.
// Data path is purely combinational (0-cycle latency).
// Optional statistics counters are built when NF10_TX_DEMUX_STATS_EN is
// defined; otherwise pkt_cnt_N and drop_cnt read 0.
//
// Handshake: every stream follows AXI4-Stream valid/ready rules -- a beat
// transfers on a cycle where tvalid and tready are both high, and a master
// never drops tvalid or changes its payload before that transfer.
module nf10_tx_port_demux
  import nf10_tx_port_demux_pkg::*;
#(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int C_NUM_PORTS        = 4
) (
  input  logic                            axi_aclk,
  input  logic                            axi_resetn,

  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic                            s_axis_tlast,

  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_0_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_0_tkeep,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_0_tuser,
  output logic                            m_axis_0_tvalid,
  input  logic                            m_axis_0_tready,
  output logic                            m_axis_0_tlast,

  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_1_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_1_tkeep,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_1_tuser,
  output logic                            m_axis_1_tvalid,
  input  logic                            m_axis_1_tready,
  output logic                            m_axis_1_tlast,

  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_2_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_2_tkeep,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_2_tuser,
  output logic                            m_axis_2_tvalid,
  input  logic                            m_axis_2_tready,
  output logic                            m_axis_2_tlast,

  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_3_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_3_tkeep,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_3_tuser,
  output logic                            m_axis_3_tvalid,
  input  logic                            m_axis_3_tready,
  output logic                            m_axis_3_tlast,

  output logic [31:0]                     pkt_cnt_0,
  output logic [31:0]                     pkt_cnt_1,
  output logic [31:0]                     pkt_cnt_2,
  output logic [31:0]                     pkt_cnt_3,
  output logic [31:0]                     drop_cnt
);

  state_e                 state_q;
  state_e                 state_d;
  logic [C_NUM_PORTS-1:0] route_q;
  logic [C_NUM_PORTS-1:0] route_d;

  logic                   s_valid;
  logic [C_NUM_PORTS-1:0] sel;
  logic [C_NUM_PORTS-1:0] mask;
  logic [C_NUM_PORTS-1:0] m_valid;
  logic [C_NUM_PORTS-1:0] m_ready;
  logic                   beat_done;

  // While reset is held nothing is presented or accepted, even though the
  // upstream may still be driving a beat.
  assign s_valid = s_axis_tvalid & axi_resetn;
  assign sel     = mac_sel(s_axis_tuser[DST_LSB +: 8]);
  assign m_ready = {m_axis_3_tready, m_axis_2_tready,
                    m_axis_1_tready, m_axis_0_tready};

  nf10_tx_demux_beat_ctrl u_beat_ctrl (
    .clk       (axi_aclk),
    .rst_n     (axi_resetn),
    .s_valid   (s_valid),
    .mask      (mask),
    .m_ready   (m_ready),
    .m_valid   (m_valid),
    .beat_done (beat_done)
  );

  // State and latched route mask.
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_q <= ST_IDLE;
      route_q <= '0;
    end else begin
      state_q <= state_d;
      route_q <= route_d;
    end
  end

  // Next state: decide on the first beat, then follow the packet to tlast.
  always_comb begin
    state_d = state_q;
    route_d = route_q;
    case (state_q)
      ST_IDLE: begin
        if (s_valid) begin
          if (sel == '0) begin
            if (!s_axis_tlast) state_d = ST_DROP;
          end else if (beat_done && !s_axis_tlast) begin
            state_d = ST_SEND;
            route_d = sel;
          end
        end
      end
      ST_SEND: begin
        if (beat_done && s_axis_tlast) state_d = ST_IDLE;
      end
      ST_DROP: begin
        if (s_valid && s_axis_tlast) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs: which ports are targeted and when the upstream beat is released.
  always_comb begin
    mask          = '0;
    s_axis_tready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sel == '0) begin
          s_axis_tready = axi_resetn;
        end else begin
          mask          = sel;
          s_axis_tready = beat_done;
        end
      end
      ST_SEND: begin
        mask          = route_q;
        s_axis_tready = beat_done;
      end
      ST_DROP: begin
        s_axis_tready = axi_resetn;
      end
      default: begin
        mask          = '0;
        s_axis_tready = 1'b0;
      end
    endcase
  end

  assign m_axis_0_tdata  = s_axis_tdata;
  assign m_axis_0_tkeep  = s_axis_tkeep;
  assign m_axis_0_tuser  = s_axis_tuser;
  assign m_axis_0_tlast  = s_axis_tlast;
  assign m_axis_0_tvalid = m_valid[0];

  assign m_axis_1_tdata  = s_axis_tdata;
  assign m_axis_1_tkeep  = s_axis_tkeep;
  assign m_axis_1_tuser  = s_axis_tuser;
  assign m_axis_1_tlast  = s_axis_tlast;
  assign m_axis_1_tvalid = m_valid[1];

  assign m_axis_2_tdata  = s_axis_tdata;
  assign m_axis_2_tkeep  = s_axis_tkeep;
  assign m_axis_2_tuser  = s_axis_tuser;
  assign m_axis_2_tlast  = s_axis_tlast;
  assign m_axis_2_tvalid = m_valid[2];

  assign m_axis_3_tdata  = s_axis_tdata;
  assign m_axis_3_tkeep  = s_axis_tkeep;
  assign m_axis_3_tuser  = s_axis_tuser;
  assign m_axis_3_tlast  = s_axis_tlast;
  assign m_axis_3_tvalid = m_valid[3];

`ifdef NF10_TX_DEMUX_STATS_EN
  logic [C_NUM_PORTS-1:0][31:0] pkt_cnt_q;
  logic [C_NUM_PORTS-1:0][31:0] pkt_cnt_d;
  logic [31:0]                  drop_cnt_q;
  logic [31:0]                  drop_cnt_d;
  logic                         drop_first;

  assign drop_first = (state_q == ST_IDLE) && s_valid && (sel == '0);

  // Count a packet per port on that port's tlast transfer; drops on first beat.
  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    for (int n = 0; n < C_NUM_PORTS; n++) begin
      if (m_valid[n] && m_ready[n] && s_axis_tlast) begin
        pkt_cnt_d[n] = pkt_cnt_q[n] + 32'd1;
      end
    end
    drop_cnt_d = drop_first ? (drop_cnt_q + 32'd1) : drop_cnt_q;
  end

  // Statistics registers, free-running and wrapping at 2^32.
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      pkt_cnt_q  <= pkt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign pkt_cnt_0 = pkt_cnt_q[0];
  assign pkt_cnt_1 = pkt_cnt_q[1];
  assign pkt_cnt_2 = pkt_cnt_q[2];
  assign pkt_cnt_3 = pkt_cnt_q[3];
  assign drop_cnt  = drop_cnt_q;
`else
  assign pkt_cnt_0 = '0;
  assign pkt_cnt_1 = '0;
  assign pkt_cnt_2 = '0;
  assign pkt_cnt_3 = '0;
  assign drop_cnt  = '0;
`endif

endmodule
